// File: rtl/cas_key_loader.sv
// CAS-Lock key loader: byte-stream key intake with CRC-8 trailer check, driving the keyinput bus.
// Optional lockout after repeated failures is enabled by defining KEY_LOCKOUT_EN.
module cas_key_loader #(
  parameter int KEY_WIDTH = 64,
  parameter logic [KEY_WIDTH-1:0] DECOY = '0,
  parameter int TIMEOUT = 1024,
  parameter int MAX_FAIL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 clear,
  output logic [KEY_WIDTH-1:0] key_o,
  output logic                 key_valid,
  output logic                 err_pulse,
  output logic [2:0]           fail_cnt,
  output logic                 locked_out
);

  localparam int KEY_BYTES = KEY_WIDTH / 8;
  localparam int CW = $clog2(KEY_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CRC,
    S_CHECK,
`ifdef KEY_LOCKOUT_EN
    S_LOCKOUT,
`endif
    S_ARMED
  } state_t;

  state_t                 state, state_next, fail_dest;
  logic [KEY_WIDTH-1:0]   shadow;
  logic [7:0]             crc, crc_next, trailer;
  logic [CW-1:0]          byte_cnt;
  logic [TW-1:0]          timer;
  logic [2:0]             fail_inc;
  logic                   xfer, in_stream, timeout_hit, crc_ok, fail_event, last_byte;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c_in, input logic [7:0] d);
    logic [7:0] c;
    c = c_in ^ d;
    for (int unsigned i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign in_stream   = (state == S_LOAD) || (state == S_CRC);
  assign s_ready     = ~rst && ((state == S_IDLE) || in_stream);
  assign xfer        = s_valid && s_ready;
  assign crc_next    = crc8_byte(crc, s_data);
  assign last_byte   = (byte_cnt == CW'(KEY_BYTES - 1));
  // A transfer on the would-be timeout cycle wins, so timeout needs an idle beat.
  assign timeout_hit = in_stream && !xfer && (timer == TW'(TIMEOUT - 1));
  assign crc_ok      = (trailer == crc);
  assign fail_event  = ((state == S_CHECK) && !crc_ok) || timeout_hit;
  assign fail_inc    = (fail_cnt == 3'd7) ? 3'd7 : fail_cnt + 3'd1;

`ifdef KEY_LOCKOUT_EN
  localparam logic [2:0] MAX_FAIL_C = (MAX_FAIL > 7) ? 3'd7 : 3'(MAX_FAIL);
  always_comb fail_dest = (fail_inc >= MAX_FAIL_C) ? S_LOCKOUT : S_IDLE;
  assign locked_out = (state == S_LOCKOUT);
`else
  always_comb fail_dest = S_IDLE;
  assign locked_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (xfer) state_next = (KEY_BYTES == 1) ? S_CRC : S_LOAD;
      S_LOAD: begin
        if (xfer && last_byte) state_next = S_CRC;
        else if (timeout_hit)  state_next = fail_dest;
      end
      S_CRC: begin
        if (xfer)             state_next = S_CHECK;
        else if (timeout_hit) state_next = fail_dest;
      end
      S_CHECK: state_next = crc_ok ? S_ARMED : fail_dest;
      S_ARMED: if (clear) state_next = S_IDLE;
      default: state_next = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_o     <= DECOY;
      key_valid <= 1'b0;
      err_pulse <= 1'b0;
      fail_cnt  <= '0;
      shadow    <= '0;
      crc       <= '0;
      trailer   <= '0;
      byte_cnt  <= '0;
      timer     <= '0;
    end else begin
      err_pulse <= fail_event;
      if (fail_event) begin
        fail_cnt <= fail_inc;
        shadow   <= '0;
        crc      <= '0;
        byte_cnt <= '0;
        timer    <= '0;
      end else begin
        case (state)
          S_IDLE, S_LOAD: begin
            if (xfer) begin
              for (int unsigned i = 0; i < KEY_BYTES; i++)
                if (byte_cnt == CW'(i)) shadow[8*i +: 8] <= s_data;
              crc      <= crc_next;
              byte_cnt <= byte_cnt + 1'b1;
              timer    <= '0;
            end else if (state == S_LOAD) begin
              timer <= timer + 1'b1;
            end
          end
          S_CRC: begin
            if (xfer) begin
              trailer <= s_data;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          S_CHECK: begin
            // Only a verified key ever reaches key_o, and in a single update.
            key_o     <= shadow;
            key_valid <= 1'b1;
            fail_cnt  <= '0;
            byte_cnt  <= '0;
          end
          S_ARMED: begin
            if (clear) begin
              key_o     <= DECOY;
              key_valid <= 1'b0;
              shadow    <= '0;
              crc       <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cas_key_loader.sv
// Self-checking bench for cas_key_loader (default parameters, KEY_LOCKOUT_EN optional).
module tb_cas_key_loader;

  localparam int TIMEOUT = 1024;
  localparam logic [63:0] DECOY = 64'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        clear = 1'b0;
  logic [63:0] key_o;
  logic        key_valid;
  logic        err_pulse;
  logic [2:0]  fail_cnt;
  logic        locked_out;

  int vectors = 0;
  int miscompares = 0;

  cas_key_loader #(
    .KEY_WIDTH(64),
    .DECOY(DECOY),
    .TIMEOUT(TIMEOUT),
    .MAX_FAIL(4)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .clear(clear), .key_o(key_o), .key_valid(key_valid), .err_pulse(err_pulse),
    .fail_cnt(fail_cnt), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  // Reference CRC-8 (poly 0x07) as a bit-serial LFSR over key bytes in arrival order.
  function automatic logic [7:0] ref_crc(input logic [63:0] key);
    logic [7:0] r = 8'h00;
    logic fb;
    for (int k = 0; k < 8; k++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ key[8*k + b];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1; s_data = b;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL beat_wait: s_ready=%0b never rose, required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] key, input logic [7:0] trailer);
    for (int k = 0; k < 8; k++) send_beat(key[8*k +: 8]);
    send_beat(trailer);
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0b want 0", s_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (key_o !== DECOY) begin miscompares++; $display("FAIL rst_key: got %h want %h", key_o, DECOY); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", key_valid); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready1: got %0b want 1", s_ready); end
    vectors++; if (fail_cnt !== 3'd0 || err_pulse !== 1'b0 || locked_out !== 1'b0) begin
      miscompares++; $display("FAIL rst_flags: fail_cnt=%0d err=%0b lock=%0b want 0/0/0", fail_cnt, err_pulse, locked_out);
    end
  endtask

  task automatic test_zero_key();
    do_reset();
    send_key(64'h0, 8'h00);
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL zero_early: key_valid=%0b want 0 one cycle after trailer", key_valid); end
    @(posedge clk); #1;
    vectors++; if (key_valid !== 1'b1) begin miscompares++; $display("FAIL zero_valid: got %0b want 1", key_valid); end
    vectors++; if (key_o !== 64'h0) begin miscompares++; $display("FAIL zero_key: got %h want 0", key_o); end
    vectors++; if (fail_cnt !== 3'd0) begin miscompares++; $display("FAIL zero_fail: got %0d want 0", fail_cnt); end
  endtask

  task automatic test_arm_clear();
    logic [63:0] key = 64'h8877665544332211;
    do_reset();
    send_key(key, ref_crc(key));
    @(posedge clk); #1;
    vectors++; if (key_o !== key || key_valid !== 1'b1) begin
      miscompares++; $display("FAIL arm_key: got %h/%0b want %h/1", key_o, key_valid, key);
    end
    // s_valid held in ARMED must not be accepted
    @(negedge clk); s_valid = 1'b1; s_data = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      vectors++; if (s_ready !== 1'b0 || key_o !== key) begin
        miscompares++; $display("FAIL armed_hold: ready=%0b key=%h want 0/%h", s_ready, key_o, key);
      end
    end
    s_valid = 1'b0;
    pulse_clear();
    vectors++; if (key_o !== DECOY || key_valid !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++; $display("FAIL clear: key=%h valid=%0b ready=%0b want %h/0/1", key_o, key_valid, s_ready, DECOY);
    end
  endtask

  task automatic test_bad_crc();
    logic [63:0] key = 64'h8877665544332211;
    do_reset();
    pulse_clear();  // clear outside ARMED is ignored
    send_key(key, ref_crc(key) ^ 8'h01);
    @(posedge clk); #1;
    vectors++; if (err_pulse !== 1'b1 || fail_cnt !== 3'd1) begin
      miscompares++; $display("FAIL bad_err: err=%0b fail_cnt=%0d want 1/1", err_pulse, fail_cnt);
    end
    vectors++; if (key_o !== DECOY || key_valid !== 1'b0) begin
      miscompares++; $display("FAIL bad_key: key=%h valid=%0b want %h/0", key_o, key_valid, DECOY);
    end
    @(posedge clk); #1;
    vectors++; if (err_pulse !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++; $display("FAIL bad_pulse_len: err=%0b ready=%0b want 0/1", err_pulse, s_ready);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] key;
    do_reset();
    for (int k = 0; k < 3; k++) send_beat(8'($urandom));
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    vectors++; if (err_pulse !== 1'b0 || s_ready !== 1'b1) begin
      miscompares++; $display("FAIL to_early: err=%0b ready=%0b want 0/1", err_pulse, s_ready);
    end
    @(posedge clk); #1;
    vectors++; if (err_pulse !== 1'b1 || fail_cnt !== 3'd1) begin
      miscompares++; $display("FAIL to_fire: err=%0b fail_cnt=%0d want 1/1", err_pulse, fail_cnt);
    end
    key = {$urandom, $urandom};
    send_key(key, ref_crc(key));
    @(posedge clk); #1;
    vectors++; if (key_o !== key || key_valid !== 1'b1 || fail_cnt !== 3'd0) begin
      miscompares++; $display("FAIL to_rearm: key=%h valid=%0b fail=%0d want %h/1/0", key_o, key_valid, fail_cnt, key);
    end
    pulse_clear();
  endtask

  task automatic test_timeout_boundary();
    logic [63:0] key = {$urandom, $urandom};
    do_reset();
    for (int k = 0; k < 3; k++) send_beat(key[8*k +: 8]);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    send_beat(key[31:24]);
    vectors++; if (err_pulse !== 1'b0) begin miscompares++; $display("FAIL to_edge: err=%0b want 0", err_pulse); end
    for (int k = 4; k < 8; k++) send_beat(key[8*k +: 8]);
    send_beat(ref_crc(key));
    @(posedge clk); #1;
    vectors++; if (key_o !== key || key_valid !== 1'b1) begin
      miscompares++; $display("FAIL to_edge_arm: key=%h valid=%0b want %h/1", key_o, key_valid, key);
    end
    pulse_clear();
  endtask

  task automatic test_lockout();
    logic [63:0] key;
    int nbad;
    do_reset();
`ifdef KEY_LOCKOUT_EN
    nbad = 4;
`else
    nbad = 8;
`endif
    for (int i = 1; i <= nbad; i++) begin
      key = {$urandom, $urandom};
      send_key(key, ref_crc(key) ^ 8'($urandom_range(1, 255)));
      @(posedge clk); #1;
      vectors++; if (err_pulse !== 1'b1 || fail_cnt !== 3'((i > 7) ? 7 : i)) begin
        miscompares++; $display("FAIL lk_count: err=%0b fail_cnt=%0d want 1/%0d", err_pulse, fail_cnt, (i > 7) ? 7 : i);
      end
    end
    key = {$urandom, $urandom};
`ifdef KEY_LOCKOUT_EN
    @(posedge clk); #1;
    vectors++; if (locked_out !== 1'b1 || s_ready !== 1'b0) begin
      miscompares++; $display("FAIL lk_enter: lock=%0b ready=%0b want 1/0", locked_out, s_ready);
    end
    @(negedge clk); s_valid = 1'b1; s_data = key[7:0];
    repeat (12) @(negedge clk);
    s_valid = 1'b0;
    pulse_clear();
    @(posedge clk); #1;
    vectors++; if (locked_out !== 1'b1 || key_valid !== 1'b0 || key_o !== DECOY) begin
      miscompares++; $display("FAIL lk_hold: lock=%0b valid=%0b key=%h want 1/0/%h", locked_out, key_valid, key_o, DECOY);
    end
    do_reset();
    #1;
    vectors++; if (locked_out !== 1'b0 || s_ready !== 1'b1 || fail_cnt !== 3'd0) begin
      miscompares++; $display("FAIL lk_exit: lock=%0b ready=%0b fail=%0d want 0/1/0", locked_out, s_ready, fail_cnt);
    end
`else
    vectors++; if (locked_out !== 1'b0) begin miscompares++; $display("FAIL lk_tied: got %0b want 0", locked_out); end
    send_key(key, ref_crc(key));
    @(posedge clk); #1;
    vectors++; if (key_o !== key || key_valid !== 1'b1 || fail_cnt !== 3'd0) begin
      miscompares++; $display("FAIL lk_rearm: key=%h valid=%0b fail=%0d want %h/1/0", key_o, key_valid, fail_cnt, key);
    end
    pulse_clear();
`endif
  endtask

  task automatic test_random_reset();
    logic [63:0] key;
    int idx, n_before, budget;
    logic acc;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      key = {$urandom, $urandom};
      n_before = $urandom_range(1, 7);
      idx = 0; budget = 0;
      while (idx < n_before && budget < 500) begin
        @(negedge clk);
        budget++;
        vectors++; if (key_o !== DECOY || key_valid !== 1'b0 || s_ready !== 1'b1) begin
          miscompares++; $display("FAIL rnd_partial: key=%h valid=%0b ready=%0b want %h/0/1", key_o, key_valid, s_ready, DECOY);
        end
        s_valid = 1'($urandom_range(0, 1));
        s_data  = key[8*idx +: 8];
        acc = s_valid && s_ready;
        @(posedge clk);
        if (acc) idx++;
      end
      if (budget >= 500) begin vectors++; miscompares++; $display("FAIL rnd_budget: idx=%0d want %0d", idx, n_before); end
      @(negedge clk); s_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      vectors++; if (key_o !== DECOY || key_valid !== 1'b0 || s_ready !== 1'b0) begin
        miscompares++; $display("FAIL rnd_rst: key=%h valid=%0b ready=%0b want %h/0/0", key_o, key_valid, s_ready, DECOY);
      end
      @(negedge clk); rst = 1'b0;
      key = {$urandom, $urandom};
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_beat(key[8*k +: 8]);
        vectors++; if (key_o !== DECOY) begin miscompares++; $display("FAIL rnd_load: key=%h want %h", key_o, DECOY); end
      end
      send_beat(ref_crc(key));
      @(posedge clk); #1;
      vectors++; if (key_o !== key || key_valid !== 1'b1 || fail_cnt !== 3'd0) begin
        miscompares++; $display("FAIL rnd_arm: key=%h valid=%0b fail=%0d want %h/1/0", key_o, key_valid, fail_cnt, key);
      end
      pulse_clear();
    end
  endtask

  initial begin
    test_reset();
    test_zero_key();
    test_arm_clear();
    test_bad_crc();
    test_timeout();
    test_timeout_boundary();
    test_lockout();
    test_random_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
